// File: rtl/decoder_scan_if.sv
// decoder_scan_if: groups the decoder/scanner inputs and registered outputs.
//   A     : direct-mode address / scan start address
//   g1    : enable, active-high
//   g2,g3 : enables, active-low
//   mode  : 0 = DIRECT, 1 = SCAN
//   dir   : scan direction, 0 = up, 1 = down
//   y     : registered decoded outputs (2^N wide)
//   addr  : address currently decoded on y
//   wrap  : one-cycle pulse when the scan counter wraps
// master drives the controls (testbench/system side), slave is the decoder.
interface decoder_scan_if #(
    parameter int N = 3
);
    localparam int W = 1 << N;

    logic [N-1:0] A;
    logic         g1;
    logic         g2;
    logic         g3;
    logic         mode;
    logic         dir;
    logic [W-1:0] y;
    logic [N-1:0] addr;
    logic         wrap;

    modport master (
        output A, g1, g2, g3, mode, dir,
        input  y, addr, wrap
    );

    modport slave (
        input  A, g1, g2, g3, mode, dir,
        output y, addr, wrap
    );
endinterface

// File: rtl/decoder_scan.sv
// decoder_scan: registered 74138-style N-to-2^N decoder with a three-pin
// enable and an auto-scan mode that steps the decoded address every DIV
// enabled cycles.
//   clk : system clock, rising edge
//   rst : synchronous active-high reset
//   bus : decoder_scan_if.slave (A, g1, g2, g3, mode, dir -> y, addr, wrap)
// Parameters: N address width, DIV cycles per scan step, ACTIVE_LOW output
// polarity (1 = selected line low, others high).
module decoder_scan #(
    parameter int N          = 3,
    parameter int DIV        = 4,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    decoder_scan_if.slave bus
);
    localparam int W  = 1 << N;
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
    localparam logic [W-1:0]  INACT    = ACTIVE_LOW ? {W{1'b1}} : {W{1'b0}};

    typedef enum logic {DIRECT = 1'b0, SCAN = 1'b1} state_e;

    state_e         state_q, state_d;
    logic [N-1:0]   addr_q, addr_d;
    logic [PW-1:0]  pre_q, pre_d;
    logic [W-1:0]   y_q, y_d;
    logic           wrap_q, wrap_d;
    logic           en;
    logic [W-1:0]   onehot;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DIRECT;
            addr_q  <= '0;
            pre_q   <= '0;
            y_q     <= INACT;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            pre_q   <= pre_d;
            y_q     <= y_d;
            wrap_q  <= wrap_d;
        end
    end

    always_comb begin
        en      = bus.g1 & ~bus.g2 & ~bus.g3;
        state_d = bus.mode ? SCAN : DIRECT;
        addr_d  = addr_q;
        pre_d   = pre_q;
        wrap_d  = 1'b0;
        onehot  = '0;
        y_d     = INACT;

        if (!bus.mode) begin
            // Direct (also the exit edge out of SCAN): prescaler is cleared.
            pre_d = '0;
            if (en) addr_d = bus.A;
        end else if (state_q == DIRECT) begin
            // Scan entry: latch the start address; this edge is count 0.
            addr_d = bus.A;
            pre_d  = '0;
        end else if (en) begin
            if (pre_q == PRE_LAST) begin
                pre_d = '0;
                if (bus.dir) begin
                    addr_d = addr_q - N'(1);
                    wrap_d = (addr_q == '0);
                end else begin
                    addr_d = addr_q + N'(1);
                    wrap_d = (addr_q == '1);
                end
            end else begin
                pre_d = pre_q + PW'(1);
            end
        end
        // Disabled scan: prescaler and address simply hold (defaults).

        onehot[addr_d] = 1'b1;
        if (en) y_d = ACTIVE_LOW ? ~onehot : onehot;
    end

    assign bus.y    = y_q;
    assign bus.addr = addr_q;
    assign bus.wrap = wrap_q;
endmodule

// File: doc/decoder_scan.md
# decoder_scan

Parametrised, registered 74138-style N-to-2^N decoder with three-pin enable, plus an auto-scan mode in which an internal counter steps the decoded address at a programmable rate. It drives digit-select lines for multiplexed seven-segment displays and LED chasers in the lab designs. In direct mode it is a drop-in clocked replacement for the combinational 3-to-8 decoder.

## Interface
Parameters:
- N, 3, address width; output width is 2^N (N ≥ 1).
- DIV, 4, clock cycles per scan step (DIV ≥ 1; DIV = 1 steps every enabled cycle).
- ACTIVE_LOW, 1, 1: selected output is 0 and the others are 1 (74138 polarity); 0: one-hot high.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; one clock, synchronous, active-high.
- A  in  N  direct-mode address; also the scan start address.
- g1  in  1  enable, active-high.
- g2  in  1  enable, active-low.
- g3  in  1  enable, active-low.
- mode  in  1  0 = DIRECT, 1 = SCAN.
- dir  in  1  scan direction: 0 = up, 1 = down.
- y  out  2^N  registered decoded outputs, polarity per ACTIVE_LOW.
- addr  out  N  address currently decoded on y (registered).
- wrap  out  1  one-cycle pulse when the scan counter wraps.

## Operation
- en = g1 & ~g2 & ~g3, sampled every clock.
- Two states, tracked by a registered copy of mode: DIRECT (mode_q = 0) and SCAN (mode_q = 1).
- DIRECT: when en = 1, addr <= A and y <= decode(A). When en = 0, y <= all inactive (all 1s if ACTIVE_LOW, else all 0s) and addr holds. Prescaler is held at 0.
- Entering SCAN (mode = 1 while mode_q = 0): addr <= A, prescaler <= 0, and y <= decode(A) if en = 1, else all inactive. The transition is immediate: this edge counts as SCAN prescaler count 0.
- SCAN with en = 1: prescaler counts 0..DIV-1. On the edge where prescaler = DIV-1, prescaler <= 0 and addr steps +1 (dir = 0) or -1 (dir = 1) modulo 2^N. y always decodes the new addr value.
- Wrap: wrap <= 1 on the step edge from 2^N-1 to 0 (up) or from 0 to 2^N-1 (down); otherwise wrap <= 0.
- SCAN with en = 0: prescaler and addr hold, y <= all inactive, wrap <= 0. When en returns, counting resumes from the held prescaler value.
- Leaving SCAN (mode = 0): behaviour is DIRECT from that edge on (addr <= A if en). Prescaler is cleared.
- A changes during SCAN are ignored after the entry edge.
- dir may change at any time; it takes effect at the next step edge.

## Timing
- All outputs are registered. Latency from any input to y, addr or wrap is exactly one clock edge.
- Reset (rst = 1 at an edge) overrides everything, including in mid-scan. It sets y = all inactive, addr = 0, wrap = 0, prescaler = 0 and mode_q = 0. The first edge with rst = 0 and mode = 1 is treated as SCAN entry.
- In SCAN with en held at 1, each addr value lasts exactly DIV cycles. A full cycle through all addresses takes DIV·2^N cycles, with one wrap pulse per cycle.
- Enable deassertion pauses the scan with no lost or extra steps. Total dwell on an address equals DIV enabled cycles.
- Exactly one bit of y is active when en was 1 at the last edge. No bit is active otherwise.

## Test plan
Defaults throughout: N = 3, DIV = 4, ACTIVE_LOW = 1.
- Reset: rst high for 2 cycles with random inputs -> y = 8'hFF, addr = 0, wrap = 0. After release with mode = 0 and en = 0, y stays 8'hFF.
- Direct sweep: g1 = 1, g2 = 0, g3 = 0, A = 0..7 held one cycle each -> one cycle later y = 8'hFE, FD, FB, F7, EF, DF, BF, 7F. Then g1 = 0 -> y = 8'hFF next cycle. Repeat with g2 = 1 and with g3 = 1 -> y = 8'hFF.
- Scan up: A = 6, mode 0 -> 1, en = 1, dir = 0 -> addr = 6 for 4 cycles, then 7 for 4 cycles, then 0. wrap is high for exactly the one cycle on which addr first becomes 0, and y = 8'hFE there. Period is 32 cycles per wrap.
- Scan down with pause: A = 1, dir = 1. Deassert g1 for 3 cycles in the middle of the dwell on 0 -> y = 8'hFF during the pause, and total enabled dwell on 0 is still 4 cycles. Next addr = 7, with a wrap pulse.
- Mid-scan events: dir flips 0 -> 1 mid-dwell -> next step goes down. rst pulse mid-scan -> addr = 0 and y = 8'hFF next edge, then scan restarts from A.
- DIV = 1, ACTIVE_LOW = 0: scan up from 0 -> addr increments every cycle and y = 8'h01, 02, 04, … 80, 01. wrap is high on each cycle where addr = 0 after stepping.
